// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and the data-memory stage.
// Data wins by default; a waiting fetch is forced through after MAX_BURST data grants.
module mem_port_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             force_if;

    // Grant: data first unless a waiting fetch has been starved long enough
    always_comb begin
        force_if = if_req & (starve_q == CNT_MAX);
        mem_gnt  = ~reset & mem_req & ~force_if;
        if_gnt   = ~reset & if_req & ~(mem_req & ~force_if);
        if_stall = if_req & ~if_gnt;
    end

    // RAM port driven by the winner; quiet bus when idle
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (mem_gnt) begin
            ram_addr  = mem_addr;
            ram_we    = mem_we;
            ram_wdata = mem_wdata;
        end else if (if_gnt) begin
            ram_addr = if_addr;
        end
    end

    // Next response owner and starvation count
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt & ~if_flush) begin
            owner_d = OWN_IF;
        end else if (mem_gnt & ~mem_we) begin
            owner_d = OWN_MEM;
        end
        starve_d = starve_q;
        if (if_gnt | ~if_req) begin
            starve_d = '0;
        end else if (mem_gnt && starve_q != CNT_MAX) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Owner and starvation state, cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Responses: a flush or reset in the return cycle squashes them
    always_comb begin
        if_rvalid  = ~reset & (owner_q == OWN_IF) & ~if_flush;
        mem_rvalid = ~reset & (owner_q == OWN_MEM);
        if_rdata   = if_rvalid  ? ram_rdata : '0;
        mem_rdata  = mem_rvalid ? ram_rdata : '0;
    end

endmodule
